// File: rtl/mips32_prog_loader_pkg.sv
// Shared definitions for the MIPS32 program loader: frame header value,
// loader FSM state encoding and the running checksum step.
package mips32_prog_loader_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // Seven live states plus two spare codes that recover to IDLE
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CSUM,
    ST_SPARE0,
    ST_SPARE1
  } state_t;

  // Checksum is a plain XOR fold of every byte between header and CSUM
  function automatic logic [7:0] csum_next(input logic [7:0] acc,
                                           input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/mips32_word_asm.sv
// Assembles four big-endian bytes into a 32-bit word. The word is presented
// combinationally together with word_done on the handshake of its last byte,
// so the caller can register the write in the same edge.
module mips32_word_asm
  import mips32_prog_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  assign word_done = byte_en && (byte_cnt == 2'd3);
  assign word      = {shreg, byte_in};

  // Count bytes within the word and shift earlier bytes toward the MSB end
  always_ff @(posedge clk1) begin
    if (rst || clr) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'h0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {shreg[15:0], byte_in};
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader: parses HDR/ADDR/CNT/DATA/CSUM frames, writes
// words into the core's unified memory and releases the core with a start PC
// once a frame's checksum matches.
module mips32_prog_loader
  import mips32_prog_loader_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [31:0]       start_pc,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [7:0]        acc;
  logic [7:0]        addr_hi;
  logic [7:0]        cnt_hi;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wcnt;
  logic [15:0]       addr_full;
  logic [15:0]       cnt_full;
  logic              accept;
  logic              asm_en;
  logic              asm_clr;
  logic              word_done;
  logic [31:0]       word;

  // The loader never stalls the stream; only reset blocks acceptance
  assign rx_ready  = !rst;
  assign accept    = rx_valid && rx_ready;
  assign addr_full = {addr_hi, rx_data};
  assign cnt_full  = {cnt_hi, rx_data};
  assign asm_en    = accept && (state == ST_DATA);
  assign asm_clr   = accept && (state == ST_IDLE) && (rx_data == HDR);

  mips32_word_asm u_word_asm (
    .clk1      (clk1),
    .rst       (rst),
    .clr       (asm_clr),
    .byte_en   (asm_en),
    .byte_in   (rx_data),
    .word_done (word_done),
    .word      (word)
  );

  // Frame parser: every transition is driven by an accepted byte
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= 8'h0;
      addr_hi   <= 8'h0;
      cnt_hi    <= 8'h0;
      addr      <= '0;
      wcnt      <= 16'h0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      cpu_hold  <= 1'b1;
      cpu_start <= 1'b0;
      start_pc  <= 32'h0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == HDR) begin
              cpu_hold <= 1'b1;
              err      <= 1'b0;
              busy     <= 1'b1;
              acc      <= 8'h0;
              state    <= ST_ADDR_H;
            end
          end
          ST_ADDR_H: begin
            acc     <= csum_next(acc, rx_data);
            addr_hi <= rx_data;
            state   <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            acc      <= csum_next(acc, rx_data);
            addr     <= ADDR_W'(addr_full);
            start_pc <= {16'h0, addr_full};
            state    <= ST_CNT_H;
          end
          ST_CNT_H: begin
            acc    <= csum_next(acc, rx_data);
            cnt_hi <= rx_data;
            state  <= ST_CNT_L;
          end
          ST_CNT_L: begin
            acc   <= csum_next(acc, rx_data);
            wcnt  <= cnt_full;
            state <= (cnt_full == 16'h0) ? ST_CSUM : ST_DATA;
          end
          ST_DATA: begin
            acc <= csum_next(acc, rx_data);
            if (word_done) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= word;
              addr      <= addr + 1'b1;
              wcnt      <= wcnt - 16'd1;
              if (wcnt == 16'd1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (rx_data == acc) begin
              cpu_start <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: directed frames from the test
// plan followed by randomized frames, checked against a frame-level model.
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic [31:0] start_pc;
  logic        busy;
  logic        err;

  int checks      = 0;
  int failures    = 0;
  int we_count    = 0;
  int start_count = 0;
  int exp_we      = 0;
  int exp_start   = 0;

  logic [31:0] words[$];

  mips32_prog_loader dut (
    .clk1      (clk1),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .cpu_start (cpu_start),
    .start_pc  (start_pc),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk1 = ~clk1;

  // Count every write strobe and start pulse seen by the memory/core side
  always @(posedge clk1) begin
    if (mem_we === 1'b1) we_count++;
    if (cpu_start === 1'b1) start_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap_max);
    repeat ($urandom_range(gap_max, 0)) @(negedge clk1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends one whole frame built from 'words' and checks it byte by byte
  task automatic applyStimulus(input logic [15:0] a, input bit bad,
                               input int gap_max);
    logic [7:0]  acc;
    logic [7:0]  b;
    logic [15:0] c;
    int          cnt;
    cnt = words.size();
    c   = 16'(cnt);
    acc = 8'h0;
    sendByte(8'hA5, gap_max);
    checkOutput("hdr_busy", 32'(busy), 1);
    checkOutput("hdr_hold", 32'(cpu_hold), 1);
    checkOutput("hdr_err_clear", 32'(err), 0);
    sendByte(a[15:8], gap_max);
    acc ^= a[15:8];
    sendByte(a[7:0], gap_max);
    acc ^= a[7:0];
    checkOutput("start_pc_latch", start_pc, {16'h0, a});
    sendByte(c[15:8], gap_max);
    acc ^= c[15:8];
    sendByte(c[7:0], gap_max);
    acc ^= c[7:0];
    for (int w = 0; w < cnt; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = words[w][k*8 +: 8];
        sendByte(b, gap_max);
        acc ^= b;
        if (k == 0) begin
          exp_we++;
          checkOutput("word_we", 32'(mem_we), 1);
          checkOutput("word_addr", 32'(mem_addr), 32'((int'(a) + w) % 1024));
          checkOutput("word_data", mem_wdata, words[w]);
        end else begin
          checkOutput("byte_no_we", 32'(mem_we), 0);
        end
      end
    end
    sendByte(bad ? (acc ^ 8'h01) : acc, gap_max);
    checkOutput("csum_busy", 32'(busy), 0);
    checkOutput("csum_start_pc", start_pc, {16'h0, a});
    if (!bad) begin
      exp_start++;
      checkOutput("good_start", 32'(cpu_start), 1);
      checkOutput("good_hold", 32'(cpu_hold), 0);
      checkOutput("good_err", 32'(err), 0);
    end else begin
      checkOutput("bad_start", 32'(cpu_start), 0);
      checkOutput("bad_hold", 32'(cpu_hold), 1);
      checkOutput("bad_err", 32'(err), 1);
    end
    @(negedge clk1);
    checkOutput("start_one_cycle", 32'(cpu_start), 0);
    checkOutput("we_total", 32'(we_count), 32'(exp_we));
    checkOutput("start_total", 32'(start_count), 32'(exp_start));
  endtask

  initial begin
    logic [15:0] ra;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h0;

    // Reset values
    @(negedge clk1);
    checkOutput("rst_ready", 32'(rx_ready), 0);
    @(negedge clk1);
    checkOutput("rst_we", 32'(mem_we), 0);
    checkOutput("rst_addr", 32'(mem_addr), 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_hold", 32'(cpu_hold), 1);
    checkOutput("rst_start", 32'(cpu_start), 0);
    checkOutput("rst_start_pc", start_pc, 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk1);
    checkOutput("ready_after_rst", 32'(rx_ready), 1);

    // Junk before a header is discarded
    sendByte(8'h00, 0);
    sendByte(8'h12, 0);
    sendByte(8'h5A, 0);
    sendByte(8'hFF, 0);
    checkOutput("junk_busy", 32'(busy), 0);
    checkOutput("junk_hold", 32'(cpu_hold), 1);

    // Single word: A5 00 00 00 01 28 01 00 78 50
    words = '{32'h28010078};
    applyStimulus(16'h0000, 1'b0, 0);

    // Same frame with CSUM 51: word still written, err set, core held
    applyStimulus(16'h0000, 1'b1, 0);

    // Address wrap at 1023 -> 0, also clears err from the bad frame
    words = '{32'hDEADBEEF, 32'h01234567};
    applyStimulus(16'h03FF, 1'b0, 1);

    // Header values inside the payload are ordinary data
    words = '{32'hA5A5A5A5};
    applyStimulus(16'h0042, 1'b0, 0);

    // CNT=0: A5 12 34 00 00 26
    words.delete();
    applyStimulus(16'h1234, 1'b0, 0);

    // Reset after the second data byte aborts the frame without a write
    sendByte(8'hA5, 0);
    sendByte(8'h00, 0);
    sendByte(8'h10, 0);
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendByte(8'hAB, 0);
    sendByte(8'hCD, 0);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    checkOutput("abort_we", 32'(mem_we), 0);
    checkOutput("abort_hold", 32'(cpu_hold), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_start_pc", start_pc, 0);
    sendByte(8'hEF, 0);
    sendByte(8'h01, 0);
    @(negedge clk1);
    checkOutput("abort_no_write", 32'(we_count), 32'(exp_we));
    words = '{32'h11223344};
    applyStimulus(16'h0010, 1'b0, 0);

    // Randomized frames with occasional bad checksums and idle gaps
    for (int f = 0; f < 10; f++) begin
      words.delete();
      for (int w = 0; w < int'($urandom_range(4, 0)); w++) words.push_back($urandom);
      ra = ($urandom_range(1, 0) == 1) ? 16'(1020 + $urandom_range(3, 0)) : 16'($urandom);
      applyStimulus(ra, ($urandom_range(3, 0) == 0), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Byte-stream program loader for the two-phase pipelined MIPS32 core. It receives a framed image over a valid/ready byte interface and writes 32-bit words into the core's unified memory through a write port. While loading, it holds the core halted. After a frame with a good checksum, it releases the core with a start PC. It replaces the bench-only practice of preloading `Mem[]` and forcing `PC`/`HALTED` hierarchically, and is the writer end of the core's memory interface.

## Interface
- `ADDR_W`, 10: memory word-address width; addresses wrap modulo 2^ADDR_W.
- `HDR`, 8'hA5: frame start byte.
- `clk1`  in  1: clock; the core's stage-1 clock, all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` valid.
- `rx_ready`  out  1: loader accepts a byte when `rx_valid & rx_ready`.
- `mem_we`  out  1: one-cycle word write strobe.
- `mem_addr`  out  ADDR_W: word address of write.
- `mem_wdata`  out  32: write data.
- `cpu_hold`  out  1: forces core `HALTED`; high while not released.
- `cpu_start`  out  1: one-cycle pulse; core loads `PC` ← `start_pc`, clears `HALTED` and `TAKEN_BRANCH`.
- `start_pc`  out  32: zero-extended frame start address.
- `busy`  out  1: frame in progress.
- `err`  out  1: sticky checksum-error flag.

## Operation
- Frame: `HDR`, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT×4 data bytes (big-endian per word, MSB first), then CSUM.
- CSUM is the XOR of every byte after `HDR` up to and excluding CSUM.
- FSM states: IDLE → ADDR_H → ADDR_L → CNT_H → CNT_L → DATA → CSUM → IDLE. Each transition happens on an accepted byte.
- CNT_L goes directly to CSUM when CNT = 0.
- IDLE: non-`HDR` bytes are discarded. Accepting `HDR` sets `cpu_hold`=1, clears `err`, sets `busy`=1, and clears the checksum accumulator.
- Address: the low ADDR_W bits of {ADDR_H, ADDR_L} are the first word address. High bits beyond ADDR_W are ignored for writes.
- `start_pc` takes the full 16-bit value, zero-extended. The core indexes `Mem` by PC directly, so PC = word address.
- DATA: a byte counter 0–3 shifts bytes into a 32-bit assembly register.
  - After the 4th byte: write the word, increment the address (wrapping at 2^ADDR_W), decrement the word counter.
  - Leave DATA for CSUM when the counter reaches 0.
- Writes are committed as each word completes. A bad checksum does not roll back memory.
- CSUM byte: if it matches the accumulator, pulse `cpu_start` and drop `cpu_hold`. Otherwise set `err`, keep `cpu_hold`=1, and issue no `cpu_start`.
- `rx_ready`=1 in all states. The loader never stalls the stream.
- A new `HDR` received while released (IDLE, `cpu_hold`=0) reasserts `cpu_hold` and starts a new frame.
- `HDR` bytes inside a frame are ordinary data.

## Timing
- Reset values: `rx_ready`=0 during the `rst` cycle, then 1. `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `cpu_start`=0, `start_pc`=0, `busy`=0, `err`=0. FSM in IDLE.
- `rst` mid-frame aborts the frame. Words already written remain; `cpu_hold` stays 1.
- `mem_we` is registered: high the cycle after the handshake of the word's 4th byte. `mem_addr` and `mem_wdata` are valid in that same cycle.
- `cpu_start` and the `cpu_hold` fall both occur the cycle after the CSUM handshake. `busy` falls the same cycle.
- `err` rises the cycle after a bad CSUM and holds until `rst` or the next accepted `HDR`.
- Back-to-back bytes on consecutive cycles are supported. Minimum frame length is 6 cycles.
- `start_pc` is stable from ADDR_L acceptance until the next frame's ADDR_L.

## Structure
- Shared package holds: `HDR` value, FSM state encoding (9 states incl. spare), and the checksum-function macro.
- One sub-module: `mips32_word_asm` (byte counter plus 32-bit shift register, `word_done` strobe). Everything else stays in the top FSM.

## Test plan
- Single word: stream `A5 00 00 00 01 28 01 00 78 50` → one `mem_we` with addr 0 and data 32'h28010078. `cpu_start` pulse, `start_pc`=0, `cpu_hold` 1→0, `err`=0.
- Eg1 program: 8 words at addr 0 plus a separate 1-word frame writing 85 at addr 120. Core then runs. At 500 ns after release, `Mem[121]` = 130.
- Bad checksum: as test 1 with CSUM 8'h51 → word still written. `err`=1, `cpu_hold` stays 1, no `cpu_start`. Next valid frame clears `err`.
- Wrap: ADDR_W=10, addr 16'h03FF, CNT=2 → writes at 1023, then 0. `start_pc`=32'h3FF.
- CNT=0: `A5 12 34 00 00 26` → no `mem_we`, `cpu_start` with `start_pc`=32'h1234. Junk bytes before `A5` are ignored.
- `rst` asserted after the 2nd data byte → `mem_we` never fires, FSM IDLE, `cpu_hold`=1. A subsequent full frame loads correctly.
